// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync/bright
// decode, and a tail-light state register that only changes at frame wrap.
module vga_timing_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 29,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state_in,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_start,
    output logic [2:0] state_out
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BP + V_ACT);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h_count;
    logic [9:0]       r_v_count;
    logic [2:0]       r_state;

    logic w_pix_en;
    logic w_h_last;
    logic w_v_last;
    logic w_frame_start;

    assign w_pix_en      = (r_div == DIV_LAST);
    assign w_h_last      = (r_h_count == H_LAST);
    assign w_v_last      = (r_v_count == V_LAST);
    assign w_frame_start = w_pix_en & w_h_last & w_v_last;

    // Divider, raster counters and frame-synchronous state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
            r_state   <= 3'b000;
        end else begin
            if (w_pix_en) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_pix_en) begin
                if (w_h_last) begin
                    r_h_count <= 10'd0;
                    r_v_count <= w_v_last ? 10'd0 : (r_v_count + 10'd1);
                end else begin
                    r_h_count <= r_h_count + 10'd1;
                end
            end

            // Latching on the wrap edge makes the new state appear exactly at (0,0).
            if (w_frame_start) begin
                r_state <= state_in;
            end
        end
    end

    assign hCount      = r_h_count;
    assign vCount      = r_v_count;
    assign hSync       = (r_h_count >= H_SYNC_C);
    assign vSync       = (r_v_count >= V_SYNC_C);
    assign bright      = (r_h_count >= H_ACT_BEG) && (r_h_count < H_ACT_END) &&
                         (r_v_count >= V_ACT_BEG) && (r_v_count < V_ACT_END);
    assign pix_en      = w_pix_en;
    assign frame_start = w_frame_start;
    assign state_out   = r_state;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: three timing generators (default, CLK_DIV=3 small, CLK_DIV=1 tiny)
// compared every cycle to an arithmetic raster model, plus table vectors and corner sequences.
module tb_vga_timing_ctrl;

    typedef struct {
        int d, hs, hb, ha, hf, vs, vb, va, vf;
    } cfg_t;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic br;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_in;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic       a_hs, a_vs, a_br, a_pe, a_fs;
    logic       b_hs, b_vs, b_br, b_pe, b_fs;
    logic       c_hs, c_vs, c_br, c_pe, c_fs;
    logic [2:0] a_st, b_st, c_st;

    cfg_t       cfg [3];
    logic [2:0] exp_st [3];
    vec_t       vecs [13];
    int         k;
    int         errors = 0;
    int         checks = 0;
    bit         rand_en;

    always #5 clk = ~clk;

    vga_timing_ctrl u_a (
        .clk(clk), .rst(rst), .state_in(state_in),
        .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
        .pix_en(a_pe), .frame_start(a_fs), .state_out(a_st)
    );

    vga_timing_ctrl #(
        .CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_FP(2),
        .V_SYNC(2), .V_BP(3), .V_ACT(5), .V_FP(2)
    ) u_b (
        .clk(clk), .rst(rst), .state_in(state_in),
        .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
        .pix_en(b_pe), .frame_start(b_fs), .state_out(b_st)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACT(3), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACT(2), .V_FP(1)
    ) u_c (
        .clk(clk), .rst(rst), .state_in(state_in),
        .hCount(c_h), .vCount(c_v), .hSync(c_hs), .vSync(c_vs), .bright(c_br),
        .pix_en(c_pe), .frame_start(c_fs), .state_out(c_st)
    );

    function automatic int frame_len(cfg_t c);
        return c.d * (c.hs + c.hb + c.ha + c.hf) * (c.vs + c.vb + c.va + c.vf);
    endfunction

    // Expected outputs after kk clock edges since reset release.
    function automatic logic [27:0] model(cfg_t c, int kk, logic [2:0] st);
        int   ht, vt, pix, h, v;
        logic pe, fs, hsy, vsy, br;
        ht  = c.hs + c.hb + c.ha + c.hf;
        vt  = c.vs + c.vb + c.va + c.vf;
        pix = kk / c.d;
        h   = pix % ht;
        v   = (pix / ht) % vt;
        pe  = ((kk % c.d) == c.d - 1);
        fs  = pe && (h == ht - 1) && (v == vt - 1);
        hsy = !(h < c.hs);
        vsy = !(v < c.vs);
        br  = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha) &&
              (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
        return {10'(h), 10'(v), hsy, vsy, br, pe, fs, st};
    endfunction

    function automatic logic [27:0] act(int i);
        case (i)
            0:       return {a_h, a_v, a_hs, a_vs, a_br, a_pe, a_fs, a_st};
            1:       return {b_h, b_v, b_hs, b_vs, b_br, b_pe, b_fs, b_st};
            2:       return {c_h, c_v, c_hs, c_vs, c_br, c_pe, c_fs, c_st};
            default: return 28'd0;
        endcase
    endfunction

    task automatic check_all();
        logic [27:0] e;
        for (int i = 0; i < 3; i++) begin
            e = model(cfg[i], k, exp_st[i]);
            checks++;
            if (act(i) !== e) begin
                errors++;
                $display("FAIL model_dut%0d k=%0d actual={h,v,hs,vs,br,pe,fs,st}=%h required=%h",
                         i, k, act(i), e);
            end
        end
    endtask

    task automatic check1(string name, int actual, int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // One clock cycle: advance model at posedge, compare at negedge, maybe perturb state_in.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            k++;
            for (int i = 0; i < 3; i++) begin
                if ((k % frame_len(cfg[i])) == 0) exp_st[i] = state_in;
            end
        end
        @(negedge clk);
        check_all();
        if (rand_en && ($urandom_range(0, 39) == 0)) state_in = 3'($urandom_range(0, 7));
    endtask

    task automatic run_to(int target);
        int n;
        n = 0;
        while (k < target && n < 100000) begin
            step();
            n++;
        end
        check1("run_to_reached", k, target);
    endtask

    initial begin
        int n;
        cfg[0] = '{2, 96, 48, 640, 16, 2, 29, 480, 10};
        cfg[1] = '{3, 4, 3, 8, 2, 2, 3, 5, 2};
        cfg[2] = '{1, 2, 1, 3, 1, 1, 1, 2, 1};
        vecs[0]  = '{0,   0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{95,  0,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{96,  0,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{799, 0,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0,   1,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{500, 1,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{500, 2,  1'b1, 1'b1, 1'b0};
        vecs[7]  = '{500, 30, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{143, 31, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{144, 31, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{783, 31, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{784, 31, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{144, 32, 1'b1, 1'b1, 1'b1};

        rst      = 1'b1;
        state_in = 3'b000;
        rand_en  = 1'b1;
        k        = 0;
        for (int i = 0; i < 3; i++) exp_st[i] = 3'b000;
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Default-timing vectors: run to each raster position and check decode.
        for (int r = 0; r < 13; r++) begin
            run_to((vecs[r].v * 800 + vecs[r].h) * 2);
            check1("vec_hcount", int'(a_h), vecs[r].h);
            check1("vec_vcount", int'(a_v), vecs[r].v);
            check1("vec_hsync",  int'(a_hs), int'(vecs[r].hs));
            check1("vec_vsync",  int'(a_vs), int'(vecs[r].vs));
            check1("vec_bright", int'(a_br), int'(vecs[r].br));
        end

        // Mid-frame asynchronous reset on the small instance at (10,6).
        n = 0;
        while (!(((k / 3) % 17) == 10 && ((k / 51) % 12) == 6) && n < 1000) begin
            step();
            n++;
        end
        check1("reach_midframe", n < 1000 ? 1 : 0, 1);
        #2 rst = 1'b1;
        k = 0;
        for (int i = 0; i < 3; i++) exp_st[i] = 3'b000;
        #1;
        check_all();
        check1("rst_b_hcount", int'(b_h), 0);
        check1("rst_a_state", int'(a_st), 0);
        step();
        step();
        rst      = 1'b0;
        rand_en  = 1'b0;
        state_in = 3'b000;
        n = 0;
        while (!a_pe && n < 10) begin
            step();
            n++;
        end
        check1("first_pix_en_edges", n, 1);

        // State latch on the small instance (frame = 612 clks).
        run_to(912);
        state_in = 3'b011;
        run_to(1223);
        check1("latch_b_fs_cycle", int'(b_fs), 1);
        check1("latch_b_before_wrap", int'(b_st), 0);
        step();
        check1("latch_b_wrap_h", int'(b_h), 0);
        check1("latch_b_wrap_v", int'(b_v), 0);
        check1("latch_b_after_wrap", int'(b_st), 3);
        state_in = 3'b101;
        run_to(1835);
        check1("latch_b_ignored", int'(b_st), 3);
        step();
        check1("latch_b_next_frame", int'(b_st), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
